// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register indices, SR/Cause field positions and exception codes.
package cp0_pkg;

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    localparam int SR_IE    = 0;
    localparam int SR_EXL   = 1;
    localparam int SR_IM_LO = 10;
    localparam int SR_IM_HI = 15;

    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_EXC_HI = 6;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_IP_HI  = 15;
    localparam int CAUSE_BD     = 31;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

endpackage

// File: rtl/cp0.sv
// MIPS-style coprocessor 0: SR/Cause/EPC/PRId, interrupt and exception entry, eret EXL clear.
module cp0
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID = 32'h0000_0711
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        WE,
    input  logic [31:0] PC,
    input  logic        BDIn,
    input  logic [4:0]  ExcIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic        IntReq,
    output logic [31:0] EPC,
    output logic [31:0] DOut
);

    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exc_q, exc_d;
    logic [31:0] epc_q, epc_d;

    logic        int_pend;
    logic        exc_pend;
    logic [31:0] victim_pc;

    assign int_pend  = (|(HWInt & im_q)) & ie_q & ~exl_q;
    assign exc_pend  = (ExcIn != 5'd0) & ~exl_q;
    assign IntReq    = int_pend | exc_pend;
    // A delay-slot victim restarts at its branch so the branch re-executes on eret.
    assign victim_pc = BDIn ? (PC - 32'd4) : PC;
    assign EPC       = epc_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            im_q  <= '0;
            exl_q <= 1'b0;
            ie_q  <= 1'b0;
            bd_q  <= 1'b0;
            ip_q  <= '0;
            exc_q <= '0;
            epc_q <= '0;
        end else begin
            im_q  <= im_d;
            exl_q <= exl_d;
            ie_q  <= ie_d;
            bd_q  <= bd_d;
            ip_q  <= ip_d;
            exc_q <= exc_d;
            epc_q <= epc_d;
        end
    end

    always_comb begin
        im_d  = im_q;
        exl_d = exl_q;
        ie_d  = ie_q;
        bd_d  = bd_q;
        ip_d  = HWInt;
        exc_d = exc_q;
        epc_d = epc_q;
        if (IntReq) begin
            // Exception entry drops any concurrent mtc0 or eret.
            exl_d = 1'b1;
            bd_d  = BDIn;
            epc_d = {victim_pc[31:2], 2'b00};
            exc_d = int_pend ? 5'(EXC_INT) : ExcIn;
        end else begin
            if (WE && (A2 == REG_SR)) begin
                im_d  = DIn[SR_IM_HI:SR_IM_LO];
                exl_d = DIn[SR_EXL];
                ie_d  = DIn[SR_IE];
            end
            if (WE && (A2 == REG_EPC)) begin
                epc_d = {DIn[31:2], 2'b00};
            end
            if (EXLClr) begin
                exl_d = 1'b0;
            end
        end
    end

    always_comb begin
        DOut = '0;
        case (A1)
            REG_SR: begin
                DOut[SR_IM_HI:SR_IM_LO] = im_q;
                DOut[SR_EXL]            = exl_q;
                DOut[SR_IE]             = ie_q;
            end
            REG_CAUSE: begin
                DOut[CAUSE_BD]                   = bd_q;
                DOut[CAUSE_IP_HI:CAUSE_IP_LO]    = ip_q;
                DOut[CAUSE_EXC_HI:CAUSE_EXC_LO]  = exc_q;
            end
            REG_EPC:  DOut = epc_q;
            REG_PRID: DOut = PRID;
            default:  DOut = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0.sv
// Self-checking bench for cp0: directed vector table, reset sequences, random run vs word-level model.
module tb_cp0;

    localparam logic [31:0] PRID = 32'h0000_0711;

    logic        clk;
    logic        reset;
    logic [4:0]  A1, A2, ExcIn;
    logic [31:0] DIn, PC, EPC, DOut;
    logic        WE, BDIn, EXLClr, IntReq;
    logic [5:0]  HWInt;

    int n_pass;
    int n_total;

    logic [31:0] m_sr, m_cause, m_epc;

    cp0 #(.PRID(PRID)) dut (
        .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn), .WE(WE),
        .PC(PC), .BDIn(BDIn), .ExcIn(ExcIn), .HWInt(HWInt), .EXLClr(EXLClr),
        .IntReq(IntReq), .EPC(EPC), .DOut(DOut)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        we;
        logic [4:0]  a2;
        logic [31:0] din;
        logic        clr;
        logic [5:0]  hw;
        logic [4:0]  exc;
        logic [31:0] pc;
        logic        bd;
        logic        exp_irq;
        logic [4:0]  a1;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vt[23];

    function automatic vec_t mk(logic we, logic [4:0] a2, logic [31:0] din, logic clr,
                                logic [5:0] hw, logic [4:0] exc, logic [31:0] pc, logic bd,
                                logic irq, logic [4:0] a1, logic [31:0] rd);
        vec_t v;
        v.we = we; v.a2 = a2; v.din = din; v.clr = clr; v.hw = hw; v.exc = exc;
        v.pc = pc; v.bd = bd; v.exp_irq = irq; v.a1 = a1; v.exp_rd = rd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    task automatic idle_inputs();
        WE = 0; A2 = 0; DIn = 0; EXLClr = 0; HWInt = 0; ExcIn = 0; PC = 0; BDIn = 0; A1 = 0;
    endtask

    // Reference model: registers as architectural 32-bit words.
    function automatic logic m_irq(input logic [5:0] hw, input logic [4:0] exc);
        logic intp;
        intp = (|(hw & m_sr[15:10])) && m_sr[0] && !m_sr[1];
        return intp || ((exc != 0) && !m_sr[1]);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return PRID;
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_step(input logic we, input logic [4:0] a2, input logic [31:0] din,
                          input logic clr, input logic [5:0] hw, input logic [4:0] exc,
                          input logic [31:0] pc, input logic bd);
        logic intp;
        logic [31:0] code, tgt;
        intp = (|(hw & m_sr[15:10])) && m_sr[0] && !m_sr[1];
        if (m_irq(hw, exc)) begin
            code    = intp ? 32'd0 : 32'(exc);
            tgt     = bd ? pc - 32'd4 : pc;
            m_sr    = m_sr | 32'h2;
            m_cause = (32'(bd) << 31) | (32'(hw) << 10) | (code << 2);
            m_epc   = tgt & ~32'h3;
        end else begin
            m_cause = (m_cause & ~32'h0000_FC00) | (32'(hw) << 10);
            if (we && a2 == 5'd12) m_sr  = din & 32'h0000_FC03;
            if (we && a2 == 5'd14) m_epc = din & ~32'h3;
            if (clr) m_sr = m_sr & ~32'h2;
        end
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        m_sr = 0; m_cause = 0; m_epc = 0;
        idle_inputs();
        reset = 1'b0;

        vt[0]  = mk(1, 12, 32'h401,       0, 6'h00, 5'd0,  32'h0,    0, 1'b0, 12, 32'h401);
        vt[1]  = mk(0, 0,  32'h0,         0, 6'h01, 5'd0,  32'h3010, 0, 1'b1, 12, 32'h403);
        vt[2]  = mk(0, 0,  32'h0,         0, 6'h01, 5'd0,  32'h0,    0, 1'b0, 13, 32'h400);
        vt[3]  = mk(0, 0,  32'h0,         0, 6'h00, 5'd0,  32'h0,    0, 1'b0, 14, 32'h3010);
        vt[4]  = mk(0, 0,  32'h0,         1, 6'h00, 5'd0,  32'h0,    0, 1'b0, 12, 32'h401);
        vt[5]  = mk(0, 0,  32'h0,         0, 6'h01, 5'd0,  32'h3014, 1, 1'b1, 14, 32'h3010);
        vt[6]  = mk(0, 0,  32'h0,         0, 6'h01, 5'd0,  32'h0,    0, 1'b0, 13, 32'h8000_0400);
        vt[7]  = mk(0, 0,  32'h0,         1, 6'h01, 5'd0,  32'h0,    0, 1'b0, 12, 32'h401);
        vt[8]  = mk(0, 0,  32'h0,         0, 6'h01, 5'd0,  32'h100,  0, 1'b1, 14, 32'h100);
        vt[9]  = mk(0, 0,  32'h0,         1, 6'h00, 5'd0,  32'h0,    0, 1'b0, 12, 32'h401);
        vt[10] = mk(0, 0,  32'h0,         0, 6'h01, 5'd12, 32'h0,    0, 1'b1, 13, 32'h400);
        vt[11] = mk(0, 0,  32'h0,         1, 6'h00, 5'd0,  32'h0,    0, 1'b0, 12, 32'h401);
        vt[12] = mk(0, 0,  32'h0,         0, 6'h00, 5'd12, 32'h200,  0, 1'b1, 13, 32'h30);
        vt[13] = mk(0, 0,  32'h0,         0, 6'h00, 5'd0,  32'h0,    0, 1'b0, 14, 32'h200);
        vt[14] = mk(1, 14, 32'h3007,      0, 6'h00, 5'd0,  32'h0,    0, 1'b0, 14, 32'h3004);
        vt[15] = mk(1, 13, 32'hFFFF_FFFF, 0, 6'h00, 5'd0,  32'h0,    0, 1'b0, 13, 32'h30);
        vt[16] = mk(1, 15, 32'h0,         0, 6'h00, 5'd0,  32'h0,    0, 1'b0, 15, PRID);
        vt[17] = mk(0, 0,  32'h0,         1, 6'h00, 5'd0,  32'h0,    0, 1'b0, 12, 32'h401);
        vt[18] = mk(1, 12, 32'h0,         0, 6'h01, 5'd0,  32'h400,  0, 1'b1, 12, 32'h403);
        vt[19] = mk(0, 0,  32'h0,         0, 6'h00, 5'd0,  32'h0,    0, 1'b0, 14, 32'h400);
        vt[20] = mk(1, 12, 32'hFC02,      1, 6'h00, 5'd0,  32'h0,    0, 1'b0, 12, 32'hFC00);
        vt[21] = mk(0, 0,  32'h0,         0, 6'h3F, 5'd5,  32'h600,  0, 1'b1, 5,  32'h0);
        vt[22] = mk(0, 0,  32'h0,         0, 6'h3F, 5'd0,  32'h0,    0, 1'b0, 13, 32'hFC14);

        // Power-on reset state
        #2;
        for (int a = 12; a <= 15; a++) begin
            A1 = 5'(a);
            #1 check($sformatf("reset_rd%0d", a), DOut, (a == 15) ? PRID : 32'h0);
        end
        check("reset_irq", {31'h0, IntReq}, 32'h0);
        check("reset_epc", EPC, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Directed vector table
        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            WE = vt[i].we; A2 = vt[i].a2; DIn = vt[i].din; EXLClr = vt[i].clr;
            HWInt = vt[i].hw; ExcIn = vt[i].exc; PC = vt[i].pc; BDIn = vt[i].bd;
            A1 = vt[i].a1;
            #1 check($sformatf("vec%0d_irq", i), {31'h0, IntReq}, {31'h0, vt[i].exp_irq});
            @(posedge clk);
            #1 A1 = vt[i].a1;
            #1 check($sformatf("vec%0d_rd", i), DOut, vt[i].exp_rd);
        end

        // Asynchronous reset mid-cycle clears everything immediately
        @(posedge clk);
        #2 idle_inputs();
        reset = 1'b0;
        #1;
        for (int a = 12; a <= 14; a++) begin
            A1 = 5'(a);
            #1 check($sformatf("async_rd%0d", a), DOut, 32'h0);
        end
        check("async_irq_idle", {31'h0, IntReq}, 32'h0);
        ExcIn = 5'd4; HWInt = 6'h01; PC = 32'h500;
        #1 check("async_irq_exc", {31'h0, IntReq}, 32'h1);
        @(posedge clk);
        #1 A1 = 5'd14;
        #1 check("rst_exc_epc", DOut, 32'h0);
        A1 = 5'd13;
        #1 check("rst_exc_cause", DOut, 32'h0);
        A1 = 5'd12;
        #1 check("rst_exc_sr", DOut, 32'h0);
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        m_sr = 0; m_cause = 0; m_epc = 0;

        // Randomized run against the word-level model
        for (int c = 0; c < 400; c++) begin
            logic [4:0] codes [5];
            codes = '{5'd0, 5'd4, 5'd5, 5'd10, 5'd12};
            @(negedge clk);
            WE     = ($urandom_range(0, 2) == 0);
            A2     = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'($urandom_range(12, 15));
            DIn    = $urandom;
            EXLClr = ($urandom_range(0, 7) == 0);
            HWInt  = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'h0;
            ExcIn  = ($urandom_range(0, 5) == 0) ? codes[$urandom_range(1, 4)] : 5'd0;
            PC     = $urandom;
            BDIn   = 1'($urandom);
            A1     = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'($urandom_range(12, 15));
            #1;
            check($sformatf("rnd%0d_irq", c), {31'h0, IntReq}, {31'h0, m_irq(HWInt, ExcIn)});
            check($sformatf("rnd%0d_rd%0d", c, A1), DOut, m_read(A1));
            @(posedge clk);
            m_step(WE, A2, DIn, EXLClr, HWInt, ExcIn, PC, BDIn);
        end
        #1 check("rnd_final_epc", EPC, m_epc);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cp0.md
CP0 -- requirements
Module: cp0

Interface
REQ-001 The module SHALL have parameter PRID, default 32'h0000_0711, the constant value returned for register 15.
REQ-002 The module SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-004 The module SHALL have port A1  input  5  read register index (mfc0).
REQ-005 The module SHALL have port A2  input  5  write register index (mtc0).
REQ-006 The module SHALL have port DIn  input  32  write data.
REQ-007 The module SHALL have port WE  input  1  write enable for A2/DIn.
REQ-008 The module SHALL have port PC  input  32  PC of the instruction currently at the commit stage (victim PC).
REQ-009 The module SHALL have port BDIn  input  1  the victim instruction is in a branch delay slot.
REQ-010 The module SHALL have port ExcIn  input  5  synchronous exception code; 0 means none.
REQ-011 The module SHALL have port HWInt  input  6  device interrupt lines [7:2]; HWInt[2] is the timer IRQ.
REQ-012 The module SHALL have port EXLClr  input  1  eret committing; clears EXL.
REQ-013 The module SHALL have port IntReq  output  1  take exception/interrupt this cycle; pipeline flushes and redirects to handler.
REQ-014 The module SHALL have port EPC  output  32  current EPC register value (eret target).
REQ-015 The module SHALL have port DOut  output  32  read data for A1.

Function
REQ-016 Registers SHALL be: SR(12) = {IM[15:10], EXL[1], IE[0]}, other bits read 0; Cause(13) = {BD[31], IP[15:10], ExcCode[6:2]}, other bits read 0; EPC(14) 32-bit, bits [1:0] always 0; PRId(15) = PRID.
REQ-017 The module SHALL define IntPend = |(HWInt & IM) & IE & !EXL.
REQ-018 The module SHALL define ExcPend = (ExcIn != 0) & !EXL.
REQ-019 IntReq SHALL be combinational: IntPend | ExcPend.
REQ-020 Cause.IP SHALL be loaded from HWInt on every clock edge, regardless of all other inputs.
REQ-021 On an edge with IntReq=1, the module SHALL take all of the following actions:
- set EXL=1;
- set BD=BDIn;
- set EPC = (BDIn ? PC-4 : PC) with bits [1:0] forced to 0;
- set ExcCode = 0 if IntPend, else ExcIn (an interrupt has priority over a simultaneous exception).
REQ-022 IntReq SHALL take priority over WE and EXLClr in the same cycle; the write and the clear SHALL be discarded.
REQ-023 Otherwise, WE SHALL update only the following:
- A2=12: IM, EXL and IE from DIn[15:10], DIn[1] and DIn[0];
- A2=14: EPC from DIn[31:2].
REQ-024 Writes to Cause, PRId and any other index SHALL be ignored.
REQ-025 If WE to SR and EXLClr occur together without IntReq, EXLClr SHALL win for the EXL bit; the other SR fields SHALL still be written.
REQ-026 DOut SHALL be combinational from A1 and reflect current register contents; unimplemented indices SHALL return 0.
REQ-027 There SHALL be no write-to-read bypass.
REQ-028 While EXL=1, all interrupts and exceptions SHALL be masked; pending HWInt SHALL remain visible in IP and be taken on the first cycle after EXL clears, if still asserted.
REQ-029 HWInt SHALL be level-sensitive, with no latching inside cp0; the device holds IRQ until it is serviced.

Reset
REQ-030 While reset=0, all of the following SHALL be held 0: IM, EXL, IE, BD, IP, ExcCode and EPC.
REQ-031 Because IE=0 and EXL=0 during reset, IntReq SHALL evaluate to 0 unless ExcIn!=0.
REQ-032 Reset assertion mid-exception SHALL abandon it immediately, with no EPC update.

Structure
REQ-033 A shared package SHALL hold the following constants:
- register indices 12/13/14/15;
- SR and Cause bit positions;
- ExcCode values: Int=0, AdEL=4, AdES=5, RI=10, Ov=12.
REQ-034 The module SHALL be a single module with no sub-modules; pending/priority logic SHALL be inline combinational.

Verification
REQ-035 The bench SHALL cover this scenario: mtc0 SR=32'h0000_0401; assert HWInt=6'b000001, PC=32'h0000_3010, BDIn=0 -> IntReq=1 same cycle; next cycle EXL=1, ExcCode=0, EPC=32'h0000_3010, IntReq=0.
REQ-036 The bench SHALL cover this scenario: the same setup with BDIn=1 and PC=32'h0000_3014 -> EPC=32'h0000_3010 and Cause[31]=1.
REQ-037 The bench SHALL cover this scenario: SR=32'h0000_0401 with ExcIn=12 and HWInt[2] asserted together -> ExcCode=0; then with HWInt=0 and ExcIn=12 after EXLClr -> ExcCode=12.
REQ-038 The bench SHALL cover this scenario: EXL=1 with HWInt[2] held -> IntReq=0 and Cause[10]=1; pulse EXLClr -> IntReq=1 on the following cycle.
REQ-039 The bench SHALL cover this scenario: WE with A2=14 and DIn=32'h0000_3007 -> EPC=32'h0000_3004; WE with A2=13 -> Cause unchanged; A1=15 -> DOut=PRID.
REQ-040 The bench SHALL cover this scenario: IntReq and WE to SR with DIn=0 in the same cycle -> the write is dropped and EXL=1; asynchronous reset pulse mid-cycle -> all registers read 0 immediately.
